id_stage_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational decode stage.
- Decodes RV32I/RV64I (XLEN-selectable), reads register operands, and checks load-use hazards against the EX stage.
- Registers the full decoded bundle into an ID/EX pipeline register with valid/ready handshakes on both sides.
- Sits between IF (instruction buffer) and EX; the regfile read port is driven combinationally from this stage.

---
 rtl/id_pkg.sv | 68 ++++++
 rtl/id_stage_pipe_decoder.sv | 189 ++++++++++++++++++
 rtl/id_stage_pipe.sv | 100 ++++++++++
 tb/tb_id_stage_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// id_pkg: opcodes, bundle bit indices and the ID/EX bundle type for id_stage_pipe.
// The mul_info field exists only when ID_RVM_EN is defined.
package id_pkg;
    localparam int MAX_XLEN = 64;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_REG    = 7'h33;
    localparam logic [6:0] OPC_IMMW   = 7'h1b;
    localparam logic [6:0] OPC_REGW   = 7'h3b;
    localparam logic [6:0] OPC_FENCE  = 7'h0f;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam int OP_W = 14;
    localparam int OP_LUI = 0, OP_AUIPC = 1, OP_JAL = 2, OP_JALR = 3, OP_BRANCH = 4;
    localparam int OP_LOAD = 5, OP_STORE = 6, OP_IMM = 7, OP_REG = 8, OP_IMMW = 9;
    localparam int OP_REGW = 10, OP_FENCE = 11, OP_SYSTEM = 12, OP_MUL = 13;

    localparam int ALU_W = 10;
    localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLL = 2, ALU_SLT = 3, ALU_SLTU = 4;
    localparam int ALU_XOR = 5, ALU_SRL = 6, ALU_SRA = 7, ALU_OR = 8, ALU_AND = 9;

    localparam int BJ_W = 8;
    localparam int BJ_BEQ = 0, BJ_BNE = 1, BJ_BLT = 2, BJ_BGE = 3;
    localparam int BJ_BLTU = 4, BJ_BGEU = 5, BJ_JAL = 6, BJ_JALR = 7;

    // Load/store/mul indices equal funct3, so decode can index directly.
    localparam int LD_W = 7;
    localparam int LD_LB = 0, LD_LH = 1, LD_LW = 2, LD_LD = 3, LD_LBU = 4, LD_LHU = 5, LD_LWU = 6;
    localparam int ST_W = 4;
    localparam int ST_SB = 0, ST_SH = 1, ST_SW = 2, ST_SD = 3;
    localparam int MUL_W = 8;
    localparam int MUL_MUL = 0, MUL_MULH = 1, MUL_MULHSU = 2, MUL_MULHU = 3;
    localparam int MUL_DIV = 4, MUL_DIVU = 5, MUL_REM = 6, MUL_REMU = 7;

    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [MAX_XLEN-1:0] op1;
        logic [MAX_XLEN-1:0] op2;
        logic [MAX_XLEN-1:0] jmp_tgt;
        logic [OP_W-1:0]     op_info;
        logic [ALU_W-1:0]    alu_info;
        logic [BJ_W-1:0]     bj_info;
        logic [LD_W-1:0]     load_info;
        logic [ST_W-1:0]     save_info;
`ifdef ID_RVM_EN
        logic [MUL_W-1:0]    mul_info;
`endif
        logic                is_word;
        logic                mem_rd;
        logic                mem_wr;
        logic                rd_w_ena;
        logic [4:0]          rd_addr;
        logic                illegal;
    } id_bundle_t;

    function automatic logic [3:0] alu_idx(input logic [2:0] f3, input logic alt);
        return f3 == 3'd0 ? (alt ? 4'(ALU_SUB) : 4'(ALU_ADD)) :
               f3 == 3'd5 ? (alt ? 4'(ALU_SRA) : 4'(ALU_SRL)) :
               f3 > 3'd5  ? 4'(f3) + 4'd2 : 4'(f3) + 4'd1;
    endfunction
endpackage

// File: rtl/id_stage_pipe_decoder.sv
// id_decoder: combinational RV32I/RV64I decode, operand and jump-target selection.
// ID_RVM_EN adds the M-extension encodings; otherwise they decode as illegal.
module id_decoder
    import id_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] r_data1,
    input  logic [XLEN-1:0] r_data2,
    output id_bundle_t      dec,
    output logic            rs1_r_ena,
    output logic [4:0]      rs1_r_addr,
    output logic            rs2_r_ena,
    output logic [4:0]      rs2_r_addr
);
    localparam logic RV64 = (XLEN == 64);

    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, op1, op2, tgt;
    logic            ill, rdw, sh_l, sh_r;

    assign opc   = in_inst[6:0];
    assign rd    = in_inst[11:7];
    assign f3    = in_inst[14:12];
    assign f7    = in_inst[31:25];
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    // shamt[5] is only meaningful on RV64
    assign sh_l = in_inst[31:26] == 6'b0 && (RV64 || !in_inst[25]);
    assign sh_r = (in_inst[31:26] == 6'b0 || in_inst[31:26] == 6'b010000) && (RV64 || !in_inst[25]);
    assign rs1_r_addr = rs1_r_ena ? in_inst[19:15] : 5'd0;
    assign rs2_r_addr = rs2_r_ena ? in_inst[24:20] : 5'd0;

    always_comb begin
        dec = '0;
        op1 = '0;
        op2 = '0;
        tgt = '0;
        rs1_r_ena = 1'b0;
        rs2_r_ena = 1'b0;
        ill = 1'b0;
        rdw = 1'b0;
        case (opc)
            OPC_LUI: begin
                dec.op_info[OP_LUI] = 1'b1;
                dec.alu_info[ALU_ADD] = 1'b1;
                op2 = imm_u;
                rdw = 1'b1;
            end
            OPC_AUIPC: begin
                dec.op_info[OP_AUIPC] = 1'b1;
                dec.alu_info[ALU_ADD] = 1'b1;
                op1 = in_pc;
                op2 = imm_u;
                rdw = 1'b1;
            end
            OPC_JAL: begin
                dec.op_info[OP_JAL] = 1'b1;
                dec.bj_info[BJ_JAL] = 1'b1;
                dec.alu_info[ALU_ADD] = 1'b1;
                op1 = in_pc;
                op2 = XLEN'(4);
                tgt = in_pc + imm_j;
                rdw = 1'b1;
            end
            OPC_JALR: begin
                dec.op_info[OP_JALR] = 1'b1;
                dec.bj_info[BJ_JALR] = 1'b1;
                dec.alu_info[ALU_ADD] = 1'b1;
                rs1_r_ena = 1'b1;
                op1 = in_pc;
                op2 = XLEN'(4);
                tgt = (r_data1 + imm_i) & ~XLEN'(1);
                rdw = 1'b1;
                ill = f3 != 3'd0;
            end
            OPC_BRANCH: begin
                dec.op_info[OP_BRANCH] = 1'b1;
                rs1_r_ena = 1'b1;
                rs2_r_ena = 1'b1;
                op1 = r_data1;
                op2 = r_data2;
                tgt = in_pc + imm_b;
                ill = f3 == 3'd2 || f3 == 3'd3;
                dec.bj_info[f3[2] ? f3 - 3'd2 : f3] = !ill;
            end
            OPC_LOAD: begin
                dec.op_info[OP_LOAD] = 1'b1;
                dec.alu_info[ALU_ADD] = 1'b1;
                rs1_r_ena = 1'b1;
                op1 = r_data1;
                op2 = imm_i;
                dec.mem_rd = 1'b1;
                rdw = 1'b1;
                ill = f3 == 3'd7 || (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
                if (f3 != 3'd7) dec.load_info[f3] = 1'b1;
            end
            OPC_STORE: begin
                dec.op_info[OP_STORE] = 1'b1;
                dec.alu_info[ALU_ADD] = 1'b1;
                rs1_r_ena = 1'b1;
                rs2_r_ena = 1'b1;
                op1 = r_data1;
                op2 = imm_s;
                dec.mem_wr = 1'b1;
                ill = f3[2] || (!RV64 && f3 == 3'd3);
                dec.save_info[f3[1:0]] = !ill;
            end
            OPC_IMM: begin
                dec.op_info[OP_IMM] = 1'b1;
                rs1_r_ena = 1'b1;
                op1 = r_data1;
                op2 = imm_i;
                rdw = 1'b1;
                ill = (f3 == 3'd1 && !sh_l) || (f3 == 3'd5 && !sh_r);
                dec.alu_info[alu_idx(f3, f3 == 3'd5 && in_inst[30])] = 1'b1;
            end
            OPC_REG: begin
                rs1_r_ena = 1'b1;
                rs2_r_ena = 1'b1;
                op1 = r_data1;
                op2 = r_data2;
                rdw = 1'b1;
`ifdef ID_RVM_EN
                if (f7 == 7'h01) begin
                    dec.op_info[OP_MUL] = 1'b1;
                    dec.mul_info[f3] = 1'b1;
                end else
`endif
                begin
                    dec.op_info[OP_REG] = 1'b1;
                    ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                    dec.alu_info[alu_idx(f3, in_inst[30])] = 1'b1;
                end
            end
            OPC_IMMW: begin
                dec.op_info[OP_IMMW] = 1'b1;
                dec.is_word = 1'b1;
                rs1_r_ena = 1'b1;
                op1 = r_data1;
                op2 = imm_i;
                rdw = 1'b1;
                ill = !RV64 || !(f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) ||
                                 (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
                dec.alu_info[alu_idx(f3, f3 == 3'd5 && in_inst[30])] = 1'b1;
            end
            OPC_REGW: begin
                dec.is_word = 1'b1;
                rs1_r_ena = 1'b1;
                rs2_r_ena = 1'b1;
                op1 = r_data1;
                op2 = r_data2;
                rdw = 1'b1;
`ifdef ID_RVM_EN
                if (f7 == 7'h01) begin
                    dec.op_info[OP_MUL] = 1'b1;
                    dec.mul_info[f3] = 1'b1;
                    ill = !RV64 || (f3 != 3'd0 && !f3[2]);
                end else
`endif
                begin
                    dec.op_info[OP_REGW] = 1'b1;
                    ill = !RV64 || !((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
                                     (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
                    dec.alu_info[alu_idx(f3, in_inst[30])] = 1'b1;
                end
            end
            OPC_FENCE:  dec.op_info[OP_FENCE] = 1'b1;
            OPC_SYSTEM: dec.op_info[OP_SYSTEM] = 1'b1;
            default:    ill = 1'b1;
        endcase
        dec.pc = MAX_XLEN'(in_pc);
        dec.op1 = MAX_XLEN'(op1);
        dec.op2 = MAX_XLEN'(op2);
        dec.jmp_tgt = MAX_XLEN'(tgt);
        dec.rd_addr = rd;
        dec.illegal = ill;
        dec.rd_w_ena = rdw && !ill && rd != 5'd0;
        dec.mem_rd = dec.mem_rd && !ill;
        dec.mem_wr = dec.mem_wr && !ill;
    end
endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: pipelined decode stage with load-use hazard stall and ID/EX register.
// Defining ID_RVM_EN enables M-extension decode and the out_mul_info port.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              rs1_r_ena,
    output logic [4:0]        rs1_r_addr,
    output logic              rs2_r_ena,
    output logic [4:0]        rs2_r_addr,
    input  logic [XLEN-1:0]   r_data1,
    input  logic [XLEN-1:0]   r_data2,
    input  logic              ex_load_valid,
    input  logic [4:0]        ex_load_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [XLEN-1:0]   out_jmp_tgt,
    output logic [OP_W-1:0]   out_op_info,
    output logic [ALU_W-1:0]  out_alu_info,
    output logic [BJ_W-1:0]   out_bj_info,
    output logic [LD_W-1:0]   out_load_info,
    output logic [ST_W-1:0]   out_save_info,
    output logic              out_is_word,
    output logic              out_mem_rd,
    output logic              out_mem_wr,
    output logic              out_rd_w_ena,
    output logic [4:0]        out_rd_addr,
`ifdef ID_RVM_EN
    output logic [MUL_W-1:0]  out_mul_info,
`endif
    output logic              out_illegal
);
    id_bundle_t dec, bundle_d, bundle_q;
    logic       valid_d, valid_q, stall;

    id_decoder #(.XLEN(XLEN)) u_dec (
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .r_data1    (r_data1),
        .r_data2    (r_data2),
        .dec        (dec),
        .rs1_r_ena  (rs1_r_ena),
        .rs1_r_addr (rs1_r_addr),
        .rs2_r_ena  (rs2_r_ena),
        .rs2_r_addr (rs2_r_addr)
    );

    // Addresses are already zeroed when the port is unused, so x0 never matches.
    assign stall = in_valid && ex_load_valid && ex_load_rd != 5'd0 &&
                   ((rs1_r_ena && rs1_r_addr == ex_load_rd) || (rs2_r_ena && rs2_r_addr == ex_load_rd));
    assign in_ready = !stall && (!valid_q || out_ready) && !flush;

    always_comb begin
        valid_d  = flush ? 1'b0 : (valid_q && !out_ready) ? valid_q : stall ? 1'b0 : in_valid;
        bundle_d = (in_valid && in_ready) ? dec : bundle_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            bundle_q    <= '0;
            bundle_q.pc <= MAX_XLEN'(RESET_PC);
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = bundle_q.pc[XLEN-1:0];
    assign out_op1       = bundle_q.op1[XLEN-1:0];
    assign out_op2       = bundle_q.op2[XLEN-1:0];
    assign out_jmp_tgt   = bundle_q.jmp_tgt[XLEN-1:0];
    assign out_op_info   = bundle_q.op_info;
    assign out_alu_info  = bundle_q.alu_info;
    assign out_bj_info   = bundle_q.bj_info;
    assign out_load_info = bundle_q.load_info;
    assign out_save_info = bundle_q.save_info;
    assign out_is_word   = bundle_q.is_word;
    assign out_mem_rd    = bundle_q.mem_rd;
    assign out_mem_wr    = bundle_q.mem_wr;
    assign out_rd_w_ena  = bundle_q.rd_w_ena;
    assign out_rd_addr   = bundle_q.rd_addr;
    assign out_illegal   = bundle_q.illegal;
`ifdef ID_RVM_EN
    assign out_mul_info  = bundle_q.mul_info;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed checks of id_stage_pipe at XLEN=64 and XLEN=32.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, ex_load_valid, flush, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc, r_data1, r_data2;
    logic [4:0]  ex_load_rd;
    int          total = 0;
    int          bad = 0;

    logic        a_in_ready, a_rs1_r_ena, a_rs2_r_ena, a_out_valid, a_out_is_word;
    logic        a_out_mem_rd, a_out_mem_wr, a_out_rd_w_ena, a_out_illegal;
    logic [4:0]  a_rs1_r_addr, a_rs2_r_addr, a_out_rd_addr;
    logic [63:0] a_out_pc, a_out_op1, a_out_op2, a_out_jmp_tgt;
    logic [13:0] a_out_op_info;
    logic [9:0]  a_out_alu_info;
    logic [7:0]  a_out_bj_info;
    logic [6:0]  a_out_load_info;
    logic [3:0]  a_out_save_info;
    logic        b_in_ready, b_rs1_r_ena, b_rs2_r_ena, b_out_valid, b_out_is_word;
    logic        b_out_mem_rd, b_out_mem_wr, b_out_rd_w_ena, b_out_illegal;
    logic [4:0]  b_rs1_r_addr, b_rs2_r_addr, b_out_rd_addr;
    logic [31:0] b_out_pc, b_out_op1, b_out_op2, b_out_jmp_tgt;
    logic [13:0] b_out_op_info;
    logic [9:0]  b_out_alu_info;
    logic [7:0]  b_out_bj_info;
    logic [6:0]  b_out_load_info;
    logic [3:0]  b_out_save_info;
`ifdef ID_RVM_EN
    logic [7:0]  a_out_mul_info, b_out_mul_info;
`endif

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(64), .RESET_PC(64'h40)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .rs1_r_ena(a_rs1_r_ena), .rs1_r_addr(a_rs1_r_addr), .rs2_r_ena(a_rs2_r_ena),
        .rs2_r_addr(a_rs2_r_addr), .r_data1(r_data1), .r_data2(r_data2), .ex_load_valid(ex_load_valid),
        .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_op1(a_out_op1), .out_op2(a_out_op2), .out_jmp_tgt(a_out_jmp_tgt),
        .out_op_info(a_out_op_info), .out_alu_info(a_out_alu_info), .out_bj_info(a_out_bj_info),
        .out_load_info(a_out_load_info), .out_save_info(a_out_save_info), .out_is_word(a_out_is_word),
        .out_mem_rd(a_out_mem_rd), .out_mem_wr(a_out_mem_wr), .out_rd_w_ena(a_out_rd_w_ena),
        .out_rd_addr(a_out_rd_addr),
`ifdef ID_RVM_EN
        .out_mul_info(a_out_mul_info),
`endif
        .out_illegal(a_out_illegal)
    );

    id_stage_pipe #(.XLEN(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst),
        .in_pc(in_pc[31:0]), .rs1_r_ena(b_rs1_r_ena), .rs1_r_addr(b_rs1_r_addr), .rs2_r_ena(b_rs2_r_ena),
        .rs2_r_addr(b_rs2_r_addr), .r_data1(r_data1[31:0]), .r_data2(r_data2[31:0]),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_out_pc), .out_op1(b_out_op1), .out_op2(b_out_op2),
        .out_jmp_tgt(b_out_jmp_tgt), .out_op_info(b_out_op_info), .out_alu_info(b_out_alu_info),
        .out_bj_info(b_out_bj_info), .out_load_info(b_out_load_info), .out_save_info(b_out_save_info),
        .out_is_word(b_out_is_word), .out_mem_rd(b_out_mem_rd), .out_mem_wr(b_out_mem_wr),
        .out_rd_w_ena(b_out_rd_w_ena), .out_rd_addr(b_out_rd_addr),
`ifdef ID_RVM_EN
        .out_mul_info(b_out_mul_info),
`endif
        .out_illegal(b_out_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; r_data1 = '0; r_data2 = '0;
        ex_load_valid = 1'b0; ex_load_rd = '0; flush = 1'b0; out_ready = 1'b1;
        tick;
        tick;
        chk("rst_valid", a_out_valid, 0);
        chk("rst_pc", a_out_pc, 64'h40);
        chk("rst_op2", a_out_op2, 0);
        chk("rst_illegal", a_out_illegal, 0);
        chk("rst_pc32", b_out_pc, 0);
        rst_n = 1'b1;

        in_pc = 64'h100; in_inst = 32'h00500093; in_valid = 1'b1;
        #1;
        chk("addi_ready", a_in_ready, 1);
        chk("addi_rs1_ena", a_rs1_r_ena, 1);
        chk("addi_rs2_ena", a_rs2_r_ena, 0);
        chk("addi_rs2_addr", a_rs2_r_addr, 0);
        tick;
        chk("addi_valid", a_out_valid, 1);
        chk("addi_pc", a_out_pc, 64'h100);
        chk("addi_op1", a_out_op1, 0);
        chk("addi_op2", a_out_op2, 5);
        chk("addi_rd", a_out_rd_addr, 1);
        chk("addi_rdw", a_out_rd_w_ena, 1);
        chk("addi_alu", a_out_alu_info, 10'h001);
        chk("addi_illegal", a_out_illegal, 0);

        in_inst = 32'h00108133; in_pc = 64'h104; r_data1 = 64'd7; r_data2 = 64'd9;
        ex_load_valid = 1'b1; ex_load_rd = 5'd2;
        #1;
        chk("nodep_ready", a_in_ready, 1);
        ex_load_rd = 5'd1;
        #1;
        chk("stall_ready", a_in_ready, 0);
        tick;
        chk("stall_bubble", a_out_valid, 0);
        ex_load_valid = 1'b0;
        #1;
        chk("unstall_ready", a_in_ready, 1);
        tick;
        chk("add_valid", a_out_valid, 1);
        chk("add_op1", a_out_op1, 7);
        chk("add_op2", a_out_op2, 9);
        chk("add_rd", a_out_rd_addr, 2);
        chk("add_pc", a_out_pc, 64'h104);

        in_inst = 32'h0020a423; in_pc = 64'h108; r_data1 = 64'h1000; r_data2 = 64'h55;
        tick;
        chk("sw_op1", a_out_op1, 64'h1000);
        chk("sw_op2", a_out_op2, 8);
        chk("sw_memwr", a_out_mem_wr, 1);
        chk("sw_rdw", a_out_rd_w_ena, 0);
        chk("sw_save", a_out_save_info, 4'b0100);
        out_ready = 1'b0; in_inst = 32'h00500093; in_pc = 64'h10c; r_data1 = '0;
        #1;
        chk("hold_ready0", a_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("hold_valid", a_out_valid, 1);
            chk("hold_pc", a_out_pc, 64'h108);
            chk("hold_op2", a_out_op2, 8);
            chk("hold_memwr", a_out_mem_wr, 1);
            chk("hold_ready", a_in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", a_in_ready, 1);
        tick;
        chk("release_pc", a_out_pc, 64'h10c);
        chk("release_op2", a_out_op2, 5);
        chk("release_memwr", a_out_mem_wr, 0);

        in_inst = 32'h010000ef; in_pc = 64'h80000000;
        tick;
        chk("jal_tgt", a_out_jmp_tgt, 64'h80000010);
        chk("jal_op1", a_out_op1, 64'h80000000);
        chk("jal_op2", a_out_op2, 4);
        chk("jal_bj", a_out_bj_info, 8'h40);
        chk("jal_rdw", a_out_rd_w_ena, 1);
        flush = 1'b1; out_ready = 1'b0; in_inst = 32'h00500093;
        #1;
        chk("flush_ready", a_in_ready, 0);
        tick;
        chk("flush_valid", a_out_valid, 0);
        flush = 1'b0; out_ready = 1'b1;

        in_inst = 32'h00208463; in_pc = 64'h200; r_data1 = 64'd3; r_data2 = 64'd3;
        tick;
        chk("beq_tgt", a_out_jmp_tgt, 64'h208);
        chk("beq_bj", a_out_bj_info, 8'h01);
        chk("beq_rdw", a_out_rd_w_ena, 0);
        chk("beq_op2", a_out_op2, 3);

        in_inst = 32'h003302e7; in_pc = 64'h300; r_data1 = 64'h1000;
        #1;
        chk("jalr_rs1_addr", a_rs1_r_addr, 6);
        chk("jalr_rs2_ena", a_rs2_r_ena, 0);
        chk("jalr_rs2_addr", a_rs2_r_addr, 0);
        tick;
        chk("jalr_tgt", a_out_jmp_tgt, 64'h1002);
        chk("jalr_op1", a_out_op1, 64'h300);
        chk("jalr_op2", a_out_op2, 4);
        chk("jalr_bj", a_out_bj_info, 8'h80);
        chk("jalr_rd", a_out_rd_addr, 5);

        in_inst = 32'h800000b7;
        tick;
        chk("lui_op1", a_out_op1, 0);
        chk("lui_op2_64", a_out_op2, 64'hffffffff80000000);
        chk("lui_op2_32", b_out_op2, 64'h80000000);

        in_inst = 32'h0000009b;
        tick;
        chk("addiw32_illegal", b_out_illegal, 1);
        chk("addiw32_rdw", b_out_rd_w_ena, 0);
        chk("addiw32_valid", b_out_valid, 1);
        chk("addiw64_illegal", a_out_illegal, 0);
        chk("addiw64_word", a_out_is_word, 1);

        in_inst = 32'h00003083;
        tick;
        chk("ld64_load", a_out_load_info, 7'h08);
        chk("ld64_memrd", a_out_mem_rd, 1);
        chk("ld32_illegal", b_out_illegal, 1);
        chk("ld32_memrd", b_out_mem_rd, 0);

        in_inst = 32'hffffffff;
        tick;
        chk("bad_illegal", a_out_illegal, 1);
        chk("bad_rdw", a_out_rd_w_ena, 0);
        chk("bad_valid", a_out_valid, 1);

        in_inst = 32'h022081b3;
        tick;
`ifdef ID_RVM_EN
        chk("mul_info", a_out_mul_info, 8'h01);
        chk("mul_illegal", a_out_illegal, 0);
`else
        chk("mul_illegal", a_out_illegal, 1);
`endif

        out_ready = 1'b0;
        tick;
        chk("pre_rst_valid", a_out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", a_out_valid, 0);
        chk("arst_pc", a_out_pc, 64'h40);
        chk("arst_valid32", b_out_valid, 0);
        #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick;
        chk("post_rst_valid", a_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
